// File: rtl/mul_share_pkg.sv
// mul_share_pkg: operand/product widths and the in-flight tag carried alongside the multiplier pipeline
package mul_share_pkg;
  localparam int MUL_W = 32;
  localparam int PROD_W = 64;
  localparam int TAG_ID_W = 3;
  typedef struct packed {
    logic v;
    logic [TAG_ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/mul_share_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick (elig, ptr in; one-hot grant, encoded gid, any out), searching from ptr+1
module rr_arbiter #(
  parameter int N = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    elig,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] gid,
  output logic            any
);
  int idx;
  always_comb begin
    grant = '0;
    gid = '0;
    any = 1'b0;
    idx = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && elig[idx]) begin
        any = 1'b1;
        grant[idx] = 1'b1;
        gid = ID_W'(idx);
      end
    end
  end
endmodule

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one fixed-latency 32x32 multiplier (req_* in, rsp_* out, mul_* to multiplier, idle)
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int MUL_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*MUL_W-1:0]  req_a,
  input  logic [N_REQ*MUL_W-1:0]  req_b,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [N_REQ*PROD_W-1:0] rsp_r,
  output logic [MUL_W-1:0]        mul_a,
  output logic [MUL_W-1:0]        mul_b,
  input  logic [PROD_W-1:0]       mul_r,
  output logic                    idle
);
  localparam int ID_W = $clog2(N_REQ);
  logic [N_REQ-1:0] elig, grant, inflight, ret;
  logic [ID_W-1:0] rr_ptr, gid;
  logic gany;
  tag_t tag_q [MUL_LATENCY];
  assign elig = req_valid & ~inflight & ~rsp_valid;
  assign req_ready = grant;
  assign idle = ~|inflight & ~|rsp_valid;
  assign mul_a = gany ? req_a[MUL_W*gid +: MUL_W] : '0;
  assign mul_b = gany ? req_b[MUL_W*gid +: MUL_W] : '0;
  rr_arbiter #(.N(N_REQ)) u_arb (
    .elig (elig),
    .ptr  (rr_ptr),
    .grant(grant),
    .gid  (gid),
    .any  (gany)
  );
  always_comb begin
    ret = '0;
    for (int j = 0; j < N_REQ; j++)
      ret[j] = tag_q[MUL_LATENCY-1].v && tag_q[MUL_LATENCY-1].id == TAG_ID_W'(j);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < MUL_LATENCY; k++) tag_q[k].v <= 1'b0;
    end else begin
      tag_q[0] <= {gany, TAG_ID_W'(gid)};
      for (int k = 1; k < MUL_LATENCY; k++) tag_q[k] <= tag_q[k-1];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= '0;
      inflight <= '0;
      rr_ptr <= ID_W'(N_REQ-1);
    end else begin
      rsp_valid <= (rsp_valid & ~rsp_ready) | ret;
      inflight <= (inflight | grant) & ~ret;
      if (gany) rr_ptr <= gid;
    end
  end
  always_ff @(posedge clk) begin
    for (int j = 0; j < N_REQ; j++)
      if (ret[j]) rsp_r[PROD_W*j +: PROD_W] <= mul_r;
  end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: scoreboard bench with a 2-stage multiplier model wired to the mul_* ports
module tb_mul_share_arbiter;
  logic clk, reset;
  logic [3:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [127:0] req_a, req_b;
  logic [255:0] rsp_r;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_r, p1;
  logic idle;
  int checks = 0, failures = 0;
  logic [63:0] sb [4][$];
  logic [3:0] busy, pv, pr;
  logic [63:0] pd [4];
  int gcyc [4];
  int cyc = 0;

  mul_share_arbiter #(.N_REQ(4), .MUL_LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_r(rsp_r), .mul_a(mul_a), .mul_b(mul_b), .mul_r(mul_r), .idle(idle)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    p1 <= 64'(mul_a) * 64'(mul_b);
    mul_r <= p1;
  end

  initial begin
    #200000;
    $display("FAIL timeout global simulation limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    busy = '0; pv = '0; pr = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        for (int i = 0; i < 4; i++) sb[i].delete();
        busy = '0; pv = '0; pr = '0;
      end else begin
        checks++;
        if ($countones(req_ready) > 1) begin
          failures++;
          $display("FAIL onehot req_ready=%b required at most one bit", req_ready);
        end
        for (int i = 0; i < 4; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            checks++;
            if (busy[i]) begin
              failures++;
              $display("FAIL regrant req%0d granted while outstanding at cycle %0d", i, cyc);
            end
            busy[i] = 1'b1;
            gcyc[i] = cyc;
            sb[i].push_back(64'(req_a[32*i +: 32]) * 64'(req_b[32*i +: 32]));
          end
          if (rsp_valid[i] && !pv[i]) begin
            checks++;
            if (!busy[i] || cyc != gcyc[i] + 3) begin
              failures++;
              $display("FAIL latency req%0d rsp at cycle %0d grant cycle %0d required +3", i, cyc, gcyc[i]);
            end
          end
          if (pv[i] && !pr[i]) begin
            checks++;
            if (!rsp_valid[i] || rsp_r[64*i +: 64] !== pd[i]) begin
              failures++;
              $display("FAIL hold req%0d valid=%b r=%h required valid=1 r=%h", i, rsp_valid[i], rsp_r[64*i +: 64], pd[i]);
            end
          end
          if (rsp_valid[i] && rsp_ready[i]) begin
            checks++;
            if (sb[i].size() == 0) begin
              failures++;
              $display("FAIL spurious req%0d rsp r=%h with nothing expected", i, rsp_r[64*i +: 64]);
            end else begin
              logic [63:0] exp;
              exp = sb[i].pop_front();
              if (rsp_r[64*i +: 64] !== exp) begin
                failures++;
                $display("FAIL product req%0d got %h required %h", i, rsp_r[64*i +: 64], exp);
              end
            end
            busy[i] = 1'b0;
          end
          pv[i] = rsp_valid[i];
          pr[i] = rsp_ready[i];
          pd[i] = rsp_r[64*i +: 64];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic do_reset();
    req_valid = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      @(negedge clk);
      if (idle) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wait_idle idle=%b required 1 within 20 cycles", idle);
    end
  endtask

  task automatic test_reset();
    req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
    do_reset();
    @(negedge clk);
    checks++;
    if (idle !== 1'b1 || rsp_valid !== 4'b0 || req_ready !== 4'b0) begin
      failures++;
      $display("FAIL reset idle=%b rsp_valid=%b req_ready=%b required 1/0000/0000", idle, rsp_valid, req_ready);
    end
  endtask

  task automatic test_single();
    tick();
    set_op(0, 32'h3, 32'h5);
    req_valid = 4'b0001;
    rsp_ready = '0;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL single_grant req_ready=%b required 0001", req_ready);
    end
    tick();
    req_valid = '0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 4'b0 || idle !== 1'b0) begin
        failures++;
        $display("FAIL single_early T+%0d rsp_valid=%b idle=%b required 0000/0", k, rsp_valid, idle);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_r[63:0] !== 64'hF || idle !== 1'b0) begin
      failures++;
      $display("FAIL single_rsp rsp_valid=%b r=%h idle=%b required 0001/f/0", rsp_valid, rsp_r[63:0], idle);
    end
    tick();
    rsp_ready = 4'b0001;
    @(negedge clk);
    checks++;
    if (idle !== 1'b0) begin
      failures++;
      $display("FAIL single_idle_hs idle=%b required 0", idle);
    end
    tick();
    rsp_ready = '0;
    @(negedge clk);
    checks++;
    if (idle !== 1'b1 || rsp_valid !== 4'b0) begin
      failures++;
      $display("FAIL single_done idle=%b rsp_valid=%b required 1/0000", idle, rsp_valid);
    end
  endtask

  task automatic test_max_operands();
    bit seen = 0;
    tick();
    set_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    req_valid = 4'b0100;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL max_grant req_ready=%b required 0100", req_ready);
    end
    tick();
    req_valid = '0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (rsp_valid[2]) begin
        seen = 1;
        break;
      end
      tick();
    end
    checks++;
    if (!seen || rsp_r[191:128] !== 64'hFFFF_FFFE_0000_0001) begin
      failures++;
      $display("FAIL max_product seen=%b r=%h required fffffffe00000001", seen, rsp_r[191:128]);
    end
    tick();
    rsp_ready = 4'hF;
    wait_idle();
  endtask

  task automatic test_all_valid();
    tick();
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 32'(i) * 32'h10000, 32'd7);
    rsp_ready = 4'hF;
    req_valid = 4'hF;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 4'(1 << (k % 4))) begin
        failures++;
        $display("FAIL rr_order cycle %0d req_ready=%b required %b", k, req_ready, 4'(1 << (k % 4)));
      end
      tick();
    end
    req_valid = '0;
    wait_idle();
  endtask

  task automatic test_back_pressure();
    bit seen = 0;
    int others = 0;
    logic [63:0] exp;
    exp = 64'(32'h101) * 64'(32'h10001);
    tick();
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 32'h100 + 32'(i), 32'h10000 + 32'(i));
    rsp_ready = 4'b1101;
    req_valid = 4'hF;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (rsp_valid[1]) begin
        seen = 1;
        break;
      end
      tick();
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL bp_rsp rsp_valid[1]=0 required 1 within 10 cycles");
    end
    for (int n = 0; n < 10; n++) begin
      tick();
      @(negedge clk);
      checks++;
      if (rsp_valid[1] !== 1'b1 || rsp_r[127:64] !== exp || req_ready[1] !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold valid=%b r=%h ready=%b required 1/%h/0", rsp_valid[1], rsp_r[127:64], req_ready[1], exp);
      end
      if (req_ready[0] || req_ready[2] || req_ready[3]) others++;
    end
    checks++;
    if (others == 0) begin
      failures++;
      $display("FAIL bp_others grants=%0d required >0", others);
    end
    tick();
    req_valid = 4'b0010;
    rsp_ready = 4'hF;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL bp_hs_cycle req_ready=%b required 0000", req_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL bp_regrant req_ready=%b required 0010", req_ready);
    end
    tick();
    req_valid = '0;
    wait_idle();
  endtask

  task automatic test_reset_mid_flight();
    tick();
    do_reset();
    set_op(0, 32'h11, 32'h22);
    set_op(1, 32'h33, 32'h44);
    rsp_ready = '0;
    req_valid = 4'b0011;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL mid_grant0 req_ready=%b required 0001", req_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL mid_grant1 req_ready=%b required 0010", req_ready);
    end
    tick();
    req_valid = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 4'b0 || idle !== 1'b1) begin
        failures++;
        $display("FAIL mid_flush cycle %0d rsp_valid=%b idle=%b required 0000/1", n, rsp_valid, idle);
      end
      tick();
    end
    req_valid = 4'b0011;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL mid_first req_ready=%b required 0001", req_ready);
    end
    tick();
    req_valid = '0;
    rsp_ready = 4'hF;
    wait_idle();
  endtask

  task automatic test_fairness_gap();
    tick();
    do_reset();
    set_op(1, 32'h5, 32'h6);
    set_op(3, 32'h7, 32'h8);
    rsp_ready = 4'hF;
    req_valid = 4'b0010;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL fair_setup req_ready=%b required 0010", req_ready);
    end
    tick();
    req_valid = '0;
    wait_idle();
    tick();
    req_valid = 4'b1010;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL fair_first req_ready=%b required 1000", req_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL fair_second req_ready=%b required 0010", req_ready);
    end
    tick();
    req_valid = '0;
    wait_idle();
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    test_reset();
    test_single();
    test_max_operands();
    test_all_valid();
    test_back_pressure();
    test_reset_mid_flight();
    test_fairness_gap();
    tick();
    checks++;
    if (sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size() != 0) begin
      failures++;
      $display("FAIL drain outstanding=%0d required 0", sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one pipelined 32x32->64 unsigned multiplier (2-cycle latency, no stall/enable, no reset) between N_REQ requesters.
- Performs round-robin arbitration and drives the multiplier operands.
- Tracks each issued operation through the fixed-latency pipeline with an ID tag.
- Steers each 64-bit product back to a per-requester response register with a valid/ready handshake.
- Sits between execution-stage clients and the shared multiplier instance; the multiplier is instantiated by the parent and wired through the mul_* ports.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MUL_LATENCY, 2, cycles from operands presented to product valid on mul_r (must match the multiplier).
- ID_W, $clog2(N_REQ), derived localparam; requester tag width.

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester operation request.
- req_ready  out  N_REQ  per-requester grant; handshake when valid&ready.
- req_a  in  N_REQ*32  operand A; requester i at [32*i+:32].
- req_b  in  N_REQ*32  operand B; same packing.
- rsp_valid  out  N_REQ  product available for requester i.
- rsp_ready  in  N_REQ  requester i consumes product.
- rsp_r  out  N_REQ*64  product; requester i at [64*i+:64].
- mul_a  out  32  operand A to shared multiplier.
- mul_b  out  32  operand B to shared multiplier.
- mul_r  in  64  product from shared multiplier.
- idle  out  1  no op in flight and no rsp_valid set.

Behaviour:
- Reset (sync, active-high) has priority over all else. It clears rsp_valid, inflight flags and all tag-pipe valids, and sets rr_ptr=N_REQ-1, so requester 0 has first priority.
- rsp_r is not reset; its value is don't-care while rsp_valid=0.
- The multiplier has no reset. Its post-reset output is ignored because the tags are cleared.
- Reset mid-operation discards all in-flight ops; no rsp_valid is produced for them.
- Eligibility: elig[i] = req_valid[i] & ~inflight[i] & ~rsp_valid[i]. Each requester has at most one outstanding op. A response slot freed by rsp_ready in cycle T makes the requester eligible from T+1, not in T.
- Arbitration (combinational):
  - Grant the first eligible index searching rr_ptr+1, rr_ptr+2, ... with wrap modulo N_REQ.
  - At most one req_ready bit is high per cycle. req_ready may depend on req_valid.
  - On a grant, rr_ptr <= granted index. With no grant, rr_ptr holds.
- Operands: mul_a/mul_b = the granted requester's req_a/req_b in the grant cycle. With no grant they are 0. They are combinational; the multiplier registers them.
- Tag pipe:
  - MUL_LATENCY stages of {v, id}. Stage 0 captures {grant_any, grant_id}; stage k captures stage k-1.
  - An op granted in cycle T has its tag at stage MUL_LATENCY-1 during cycle T+MUL_LATENCY, the cycle mul_r holds its product.
- Retire:
  - When the last stage v=1 with id=j, capture rsp_r[j] <= mul_r, set rsp_valid[j] and clear inflight[j].
  - Request-handshake to rsp_valid latency = MUL_LATENCY+1 (3 by default).
- Response hold: rsp_valid[j] and rsp_r[j] stay stable until rsp_valid[j]&rsp_ready[j] at a posedge, then rsp_valid[j] clears.
- Collision-free by construction: retire to j cannot coincide with rsp_valid[j]=1, because inflight[j] blocks the grant.
- inflight[i] is set on grant and cleared on retire.
- Throughput: one op per cycle aggregate when at least MUL_LATENCY+2 requesters are eligible. A single requester with rsp_ready tied high issues once every MUL_LATENCY+2 cycles.
- Arithmetic: unsigned 32x32, full 64-bit product, no truncation.
- idle = ~|inflight & ~|rsp_valid.

Decomposition:
- Shared package mul_share_pkg holds:
  - the MUL_W=32 and PROD_W=64 constants;
  - the typedef of the tag struct {logic v; logic [ID_W-1:0] id} (parameterised via the module, or a max-width ID of 3 bits in the package).
- One natural sub-module: rr_arbiter (eligible vector + rr_ptr in, one-hot grant + encoded id out, purely combinational). It is reusable for other shared functional units.

Test Plan:
1. Reset, then single op: req_valid[0]=1, a=0x0000_0003, b=0x0000_0005. Required: req_ready[0]=1 in cycle T; rsp_valid[0] rises at T+3 with rsp_r[0]=0x0000_0000_0000_000F; idle=0 until rsp consumed.
2. Max operands: a=b=0xFFFF_FFFF on requester 2. Required: rsp_r[2]=0xFFFF_FFFE_0000_0001, with no carry loss across 16-bit partial-product boundaries.
3. All 4 requesters valid continuously with rsp_ready=1. Required:
   - grants in order 0,1,2,3,0,... one per cycle;
   - each requester's next grant is no earlier than 4 cycles after its previous one;
   - products match the per-requester operands (e.g. i*0x10000 x 7).
4. Backpressure: requester 1 completes with rsp_ready[1]=0 for 10 cycles. Required: rsp_valid[1] and rsp_r[1] stable, and requester 1 never re-granted meanwhile. Other requesters continue being granted; requester 1 is re-granted the cycle after the rsp handshake if still valid.
5. Reset mid-flight: grant requesters 0 and 1 on consecutive cycles, then assert reset for 1 cycle before either retires. Required: no rsp_valid afterwards, idle=1, next grant goes to requester 0 first.
6. Fairness with a gap: only requesters 3 and 1 valid, rr_ptr=1. Required: requester 3 is granted before requester 1.
